// File: rtl/crypto_wallet2_nios_fast_rng_collector.sv
// Entropy collector: samples the raw RNG byte, health-checks it, packs words
// into a small FIFO and serves them to the Nios II over Avalon-MM.
module crypto_wallet2_nios_fast_rng_collector #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          REP_LIMIT  = 8,
    parameter logic [15:0] DIV_RESET  = 16'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  rng_in,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_DIV    = 2'd3;

    logic          enable;
    logic          irq_en;
    logic          fault;
    logic [15:0]   divider;
    logic [15:0]   div_cnt;
    logic [1:0]    byte_idx;
    logic [23:0]   partial;
    logic [7:0]    prev_sample;
    logic [7:0]    rep_cnt;
    logic [7:0]    rep_next;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          wr_ctrl;
    logic          wr_div;
    logic          clear;
    logic          rd_data;
    logic          not_empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          running;
    logic          sample;
    logic          trip;
    logic          word_done;
    logic [31:0]   full_word;
    logic [31:0]   status;
    logic [31:0]   ctrl_rd;
    logic          unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    assign wr_ctrl   = write && (address == A_CTRL);
    assign wr_div    = write && (address == A_DIV);
    assign clear     = wr_ctrl && writedata[1];
    assign rd_data   = read && (address == A_DATA);

    assign not_empty = (count != '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = rd_data && not_empty;

    assign running   = enable && !fault;
    // Clear wins over a sample landing in the same cycle
    assign sample    = running && (div_cnt == 16'd0) && !clear;

    always_comb begin
        rep_next = 8'd1;
        if (rep_cnt != 8'd0 && rng_in == prev_sample) begin
            rep_next = (rep_cnt == 8'hFF) ? rep_cnt : rep_cnt + 8'd1;
        end
    end

    assign trip      = sample && (rep_next == 8'(REP_LIMIT));
    assign word_done = sample && !trip && (byte_idx == 2'd3);
    assign push      = word_done && (!full || pop);
    assign full_word = {rng_in, partial};

    assign status  = {23'd0, 5'(count), enable, fault, full, not_empty};
    assign ctrl_rd = {29'd0, irq_en, 1'b0, enable};

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= DIV_RESET;
        end else if (wr_div) begin
            div_cnt <= writedata[15:0];
        end else if (running) begin
            div_cnt <= (div_cnt == 16'd0) ? divider : div_cnt - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable      <= 1'b0;
            irq_en      <= 1'b0;
            fault       <= 1'b0;
            divider     <= DIV_RESET;
            byte_idx    <= 2'd0;
            partial     <= 24'd0;
            prev_sample <= 8'd0;
            rep_cnt     <= 8'd0;
        end else begin
            if (wr_ctrl) begin
                enable <= writedata[0];
                irq_en <= writedata[2];
            end
            if (wr_div) begin
                divider <= writedata[15:0];
            end
            if (clear) begin
                fault    <= 1'b0;
                byte_idx <= 2'd0;
                partial  <= 24'd0;
                rep_cnt  <= 8'd0;
            end else if (sample) begin
                prev_sample <= rng_in;
                rep_cnt     <= rep_next;
                // A tripping sample poisons the whole partial word
                if (trip) begin
                    fault    <= 1'b1;
                    byte_idx <= 2'd0;
                    partial  <= 24'd0;
                end else if (byte_idx == 2'd3) begin
                    byte_idx <= 2'd0;
                    partial  <= 24'd0;
                end else begin
                    partial[{byte_idx, 3'b000} +: 8] <= rng_in;
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= full_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'd0;
        end else if (read) begin
            unique case (address)
                A_DATA:   readdata <= not_empty ? mem[rd_ptr] : 32'd0;
                A_STATUS: readdata <= status;
                A_CTRL:   readdata <= ctrl_rd;
                A_DIV:    readdata <= {16'd0, divider};
                default:  readdata <= 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en && not_empty;
        end
    end

endmodule
